// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register slice: default operand and
// register-specifier widths, ALU operation class encodings, and the packed
// control bundle carried from decode into execute.
// No ports (package).
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  // Decoded control signals that travel together into EX. A value of all
  // zeros is a harmless bubble: nothing is written and memory is untouched.
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundle of every decode-side input and EX-side output of the ID/EX register.
// Ports of the interface itself: none (parameters DATA_W, REG_W only).
// Modports:
//   master - the decode stage / environment: drives the *_in side, id_valid and
//            flush; observes the *_out side, ex_valid, stall and stall_count.
//   slave  - the ID/EX register itself (reverse directions).
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);

  logic              id_valid;
  logic              flush;
  logic [DATA_W-1:0] read_data1_in;
  logic [DATA_W-1:0] read_data2_in;
  logic [DATA_W-1:0] sign_extend_in;
  logic [REG_W-1:0]  rs_in;
  logic [REG_W-1:0]  rt_in;
  logic [REG_W-1:0]  rd_in;
  logic              RegWrite_in;
  logic              MemtoReg_in;
  logic              MemRead_in;
  logic              MemWrite_in;
  logic              ALUSrc_in;
  logic              RegDst_in;
  logic [1:0]        ALUOp_in;

  logic [DATA_W-1:0] read_data1_out;
  logic [DATA_W-1:0] read_data2_out;
  logic [DATA_W-1:0] sign_extend_out;
  logic [REG_W-1:0]  rs_out;
  logic [REG_W-1:0]  rt_out;
  logic [REG_W-1:0]  rd_out;
  logic              RegWrite_out;
  logic              MemtoReg_out;
  logic              MemRead_out;
  logic              MemWrite_out;
  logic              ALUSrc_out;
  logic              RegDst_out;
  logic [1:0]        ALUOp_out;
  logic              ex_valid;
  logic              stall;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, flush, read_data1_in, read_data2_in, sign_extend_in,
           rs_in, rt_in, rd_in, RegWrite_in, MemtoReg_in, MemRead_in,
           MemWrite_in, ALUSrc_in, RegDst_in, ALUOp_in,
    input  read_data1_out, read_data2_out, sign_extend_out, rs_out, rt_out,
           rd_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
           ALUSrc_out, RegDst_out, ALUOp_out, ex_valid, stall, stall_count
  );

  modport slave (
    input  id_valid, flush, read_data1_in, read_data2_in, sign_extend_in,
           rs_in, rt_in, rd_in, RegWrite_in, MemtoReg_in, MemRead_in,
           MemWrite_in, ALUSrc_in, RegDst_in, ALUOp_in,
    output read_data1_out, read_data2_out, sign_extend_out, rs_out, rt_out,
           rd_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
           ALUSrc_out, RegDst_out, ALUOp_out, ex_valid, stall, stall_count
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect
// Combinational load-use hazard detector. A load sitting in EX whose
// destination (rt) is read by the instruction in decode forces one stall.
// Ports:
//   id_valid    in  - decode holds a real instruction
//   flush       in  - decode instruction is being squashed
//   ex_valid    in  - EX holds a real instruction
//   ex_mem_read in  - EX instruction is a load
//   ex_rt       in  - EX load destination register
//   id_rs/id_rt in  - decode source registers
//   stall       out - hold PC and IF/ID, insert a bubble
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             id_valid,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             stall
);

  // Register 0 is hard-wired zero, so a load into it never creates a real
  // dependency. A flushed decode instruction is discarded, so it cannot stall.
  always_comb begin
    stall = id_valid && !flush && ex_valid && ex_mem_read &&
            (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with optional load-use hazard detection.
// Build option: define ID_EX_HAZARD_EN to include hazard_detect and the
// saturating stall counter; otherwise stall and stall_count are tied to 0.
// Ports:
//   clk    in - rising-edge clock
//   rst_n  in - synchronous active-low reset
//   bus    id_ex_stage_if.slave - decode inputs, EX outputs, stall status
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q;
  ctrl_t             ctrl_q, ctrl_in;
  logic              valid_q;
  logic              load_bubble;

  always_comb begin
    ctrl_in = '{reg_write:  bus.RegWrite_in,
                mem_to_reg: bus.MemtoReg_in,
                mem_read:   bus.MemRead_in,
                mem_write:  bus.MemWrite_in,
                alu_src:    bus.ALUSrc_in,
                reg_dst:    bus.RegDst_in,
                alu_op:     alu_op_e'(bus.ALUOp_in)};
  end

  // A bubble is fully zeroed, data included, so EX never sees stale operands.
  assign load_bubble = bus.flush || bus.stall || !bus.id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n || load_bubble) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_in;
      rd1_q   <= bus.read_data1_in;
      rd2_q   <= bus.read_data2_in;
      imm_q   <= bus.sign_extend_in;
      rs_q    <= bus.rs_in;
      rt_q    <= bus.rt_in;
      rd_q    <= bus.rd_in;
    end
  end

`ifdef ID_EX_HAZARD_EN
  logic        hz_stall;
  logic [15:0] stall_count_q;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_valid    (bus.id_valid),
    .flush       (bus.flush),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_rs       (bus.rs_in),
    .id_rt       (bus.rt_in),
    .stall       (hz_stall)
  );

  assign bus.stall = hz_stall;

  // Counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (bus.stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall       = 1'b0;
  assign bus.stall_count = '0;
`endif

  assign bus.ex_valid        = valid_q;
  assign bus.read_data1_out  = rd1_q;
  assign bus.read_data2_out  = rd2_q;
  assign bus.sign_extend_out = imm_q;
  assign bus.rs_out          = rs_q;
  assign bus.rt_out          = rt_q;
  assign bus.rd_out          = rd_q;
  assign bus.RegWrite_out    = ctrl_q.reg_write;
  assign bus.MemtoReg_out    = ctrl_q.mem_to_reg;
  assign bus.MemRead_out     = ctrl_q.mem_read;
  assign bus.MemWrite_out    = ctrl_q.mem_write;
  assign bus.ALUSrc_out      = ctrl_q.alu_src;
  assign bus.RegDst_out      = ctrl_q.reg_dst;
  assign bus.ALUOp_out       = ctrl_q.alu_op;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand width; REG_W, default 5, register-specifier width.
REQ-002 Ports SHALL be (name direction width meaning), one clock, synchronous active-low reset, as follows:
- clk in 1: rising-edge clock.
- rst_n in 1: synchronous active-low reset.
- id_valid in 1: decode stage holds a real instruction.
- flush in 1: branch/jump taken; squash the decode instruction.
- read_data1_in, read_data2_in in DATA_W: register-file operands.
- sign_extend_in in DATA_W: sign-extended immediate.
- rs_in, rt_in, rd_in in REG_W: register specifiers.
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in, RegDst_in in 1 each: decoded controls.
- ALUOp_in in 2: ALU operation class.
- Matching *_out ports (same widths, without _in suffix, plus _out) out: registered EX-stage copies; read_data2_out and sign_extend_out with ALUSrc_out feed the EX ALU-source mux.
- ex_valid out 1: EX holds a real instruction.
- stall out 1: hold PC and IF/ID this cycle.
- stall_count out 16: saturating count of stall cycles.

Function
REQ-003 On each rising clk with rst_n=1, flush=0, stall=0, id_valid=1, every *_out SHALL load its *_in value and ex_valid SHALL become 1 (latency one cycle).
REQ-004 With id_valid=0 (no flush, no stall), a bubble SHALL be loaded: ex_valid=0, all control outputs 0, data/specifier outputs 0.
REQ-005 flush=1 SHALL load a bubble regardless of id_valid and hazard state.
REQ-006 stall SHALL be combinational: 1 when id_valid=1, flush=0, ex_valid=1, MemRead_out=1, rt_out!=0, and (rt_out==rs_in or rt_out==rt_in); otherwise 0.
REQ-007 When stall=1 a bubble SHALL be loaded; the decode instruction is retained upstream and re-presented next cycle.
REQ-008 A load-use hazard SHALL produce exactly one stall cycle; the bubble clears ex_valid, so stall SHALL be 0 next cycle for the same instruction.
REQ-009 Flush SHALL take priority over stall; stall SHALL read 0 whenever flush=1.
REQ-010 stall_count SHALL increment by 1 on each clock edge where stall=1, SHALL saturate at 16'hFFFF, and SHALL not wrap.
REQ-011 Register 0 as a load destination (rt_out==0) SHALL never cause a stall.

Reset
REQ-012 rst_n=0 at a rising edge SHALL set every output register to 0 (ex_valid=0, controls 0, data 0, stall_count 0), overriding flush and stall.
REQ-013 Reset asserted mid-stall SHALL leave stall=0 from the next cycle on, because ex_valid is 0.

Configuration
REQ-014 Macro ID_EX_HAZARD_EN defined: load-use detection per REQ-006..REQ-011 SHALL be built in.
REQ-015 Macro ID_EX_HAZARD_EN undefined: stall SHALL be tied 0, stall_count tied 0, and the register SHALL behave per REQ-003..REQ-005 only.

Structure
REQ-016 A shared package SHALL hold DATA_W/REG_W defaults, the ALUOp encodings (00 add, 01 sub, 10 R-type), and a packed control-bundle typedef.
REQ-017 Load-use detection SHALL live in sub-module hazard_detect; id_ex_stage instantiates it only under ID_EX_HAZARD_EN.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Pass-through: read_data2_in=10, sign_extend_in=20, ALUSrc_in=1, id_valid=1 -> next cycle read_data2_out=10, sign_extend_out=20, ALUSrc_out=1, ex_valid=1.
- Load-use: EX holds lw with rt=8; decode has add with rs_in=8 -> stall=1 for one cycle, bubble (ex_valid=0, RegWrite_out=0), add enters EX next cycle, stall_count=1.
- Flush with hazard: hazard conditions of the load-use scenario plus flush=1 -> stall=0, bubble loaded, stall_count unchanged.
- $zero: EX holds lw with rt=0; decode has rs_in=0 -> stall=0.
- Reset mid-op: rst_n=0 while ex_valid=1, MemWrite_out=1 -> next cycle all outputs 0.
- Saturation: force 65536 stall cycles -> stall_count holds 16'hFFFF.
